// File: rtl/gpu_sched_pkg.sv
// Shared types and sizing helpers for the warp dispatcher.
package gpu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } disp_state_t;

    localparam int DEF_THREADS_PER_BLOCK = 16;
    localparam int DEF_WARP_SIZE         = 4;

    function automatic int calc_num_warps(int threads_per_block, int warp_size);
        return threads_per_block / warp_size;
    endfunction

    function automatic int calc_wid_w(int num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

    function automatic int calc_tc_w(int threads_per_block);
        return $clog2(threads_per_block) + 1;
    endfunction

    function automatic int warps_needed(int count, int warp_size);
        return (count + warp_size - 1) / warp_size;
    endfunction

endpackage

// File: rtl/lane_mask_gen.sv
// Per-lane active mask for a warp starting at thread index base within a block of count threads.
module lane_mask_gen #(
    parameter int WARP_SIZE = 4,
    parameter int TC_W      = 5
) (
    input  logic [TC_W-2:0]      base,
    input  logic [TC_W-1:0]      count,
    output logic [WARP_SIZE-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int l = 0; l < WARP_SIZE; l++) begin
            mask[l] = ({1'b0, base} + TC_W'(l)) < count;
        end
    end

endmodule

// File: rtl/warp_dispatcher.sv
// Splits a block launch into warps, issues them over valid/ready and tracks retirement.
// Optional perf counters are built only when WARP_DISPATCH_PERF_EN is defined.
module warp_dispatcher
    import gpu_sched_pkg::*;
#(
    parameter int  THREADS_PER_BLOCK = DEF_THREADS_PER_BLOCK,
    parameter int  WARP_SIZE         = DEF_WARP_SIZE,
    localparam int NUM_WARPS         = calc_num_warps(THREADS_PER_BLOCK, WARP_SIZE),
    localparam int WID_W             = calc_wid_w(NUM_WARPS),
    localparam int TC_W              = calc_tc_w(THREADS_PER_BLOCK)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [TC_W-1:0]      thread_count,
    output logic                 busy,
    output logic                 done,
    output logic                 warp_valid,
    input  logic                 warp_ready,
    output logic [WID_W-1:0]     warp_id,
    output logic [TC_W-2:0]      warp_base,
    output logic [WARP_SIZE-1:0] warp_mask,
    input  logic                 warp_retire,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          block_cycles
);

    disp_state_t          state, nxt;
    logic [TC_W-1:0]      count_q, issued, outstanding;
    logic [TC_W-1:0]      clamped, gen_count, last_id;
    logic [TC_W-2:0]      gen_base;
    logic [WARP_SIZE-1:0] gen_mask;
    logic                 accept, hs, last;

    assign clamped   = (thread_count > TC_W'(THREADS_PER_BLOCK)) ? TC_W'(THREADS_PER_BLOCK) : thread_count;
    // busy still covers the done pulse cycle, so a start there is not taken
    assign accept    = (state == IDLE) && start && !busy;
    assign hs        = warp_valid && warp_ready;
    assign last_id   = TC_W'(warps_needed(int'(count_q), WARP_SIZE) - 1);
    assign last      = (issued == last_id);
    assign gen_base  = accept ? '0 : warp_base + (TC_W-1)'(WARP_SIZE);
    assign gen_count = accept ? clamped : count_q;

    lane_mask_gen #(.WARP_SIZE(WARP_SIZE), .TC_W(TC_W)) u_mask (
        .base  (gen_base),
        .count (gen_count),
        .mask  (gen_mask)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = (clamped == '0) ? DONE : ISSUE;
            ISSUE:   if (hs && last) nxt = DRAIN;
            DRAIN:   if (outstanding == '0 || (outstanding == TC_W'(1) && warp_retire)) nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            warp_valid  <= 1'b0;
            warp_id     <= '0;
            warp_base   <= '0;
            warp_mask   <= '0;
            count_q     <= '0;
            issued      <= '0;
            outstanding <= '0;
        end else begin
            state      <= nxt;
            busy       <= (nxt != IDLE) || (state == DONE);
            done       <= (state == DONE);
            warp_valid <= (nxt == ISSUE);
            if (accept) begin
                count_q <= clamped;
                issued  <= '0;
            end else if (hs) begin
                issued <= issued + TC_W'(1);
            end
            if (accept || (hs && !last)) begin
                warp_id   <= accept ? '0 : warp_id + WID_W'(1);
                warp_base <= gen_base;
                warp_mask <= gen_mask;
            end
            // a retire coinciding with a handshake cancels out
            if (hs && !warp_retire) begin
                outstanding <= outstanding + TC_W'(1);
            end else if (!hs && warp_retire && outstanding != '0) begin
                outstanding <= outstanding - TC_W'(1);
            end
        end
    end

`ifdef WARP_DISPATCH_PERF_EN
    logic [31:0] stall_q, block_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            block_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
            block_q <= '0;
        end else begin
            if (warp_valid && !warp_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (busy && block_q != '1) block_q <= block_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign block_cycles = block_q;
`else
    assign stall_cycles = '0;
    assign block_cycles = '0;
`endif

endmodule

// File: tb/tb_warp_dispatcher.sv
// Randomized and directed bench for warp_dispatcher against a transaction-level model.
module tb_warp_dispatcher;

    localparam int TPB   = 16;
    localparam int WS    = 4;
    localparam int WID_W = 2;
    localparam int TC_W  = 5;

    logic            clk = 1'b0;
    logic            reset, start, warp_ready, warp_retire;
    logic [TC_W-1:0] thread_count;
    logic            busy, done, warp_valid;
    logic [WID_W-1:0] warp_id;
    logic [TC_W-2:0] warp_base;
    logic [WS-1:0]   warp_mask;
    logic [31:0]     stall_cycles, block_cycles;

    int passed = 0;
    int total  = 0;

    warp_dispatcher #(.THREADS_PER_BLOCK(TPB), .WARP_SIZE(WS)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .thread_count (thread_count),
        .busy         (busy),
        .done         (done),
        .warp_valid   (warp_valid),
        .warp_ready   (warp_ready),
        .warp_id      (warp_id),
        .warp_base    (warp_base),
        .warp_mask    (warp_mask),
        .warp_retire  (warp_retire),
        .stall_cycles (stall_cycles),
        .block_cycles (block_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int exp_mask(int cnt, int k);
        int n;
        n = cnt - k * WS;
        return (n >= WS) ? (1 << WS) - 1 : (1 << n) - 1;
    endfunction

    // mode 0: ready always 1, retire as soon as anything is outstanding
    // mode 1: random ready/retire, spurious retires and ignored starts
    // mode 2: like mode 0 but warp 1 waits 3 cycles for ready
    task automatic run_block(input int cnt_in, input int mode);
        int cnt, nw, k, outst, last_hs, z, exp_done, stalls, stall_run, c;
        logic exp_valid, rdy, ret, hs;
        cnt = (cnt_in > TPB) ? TPB : cnt_in;
        nw  = (cnt + WS - 1) / WS;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_valid", warp_valid, 0);
        start = 1'b1; thread_count = TC_W'(cnt_in); warp_ready = 1'b0; warp_retire = 1'b0;
        k = 0; outst = 0; last_hs = -1; z = -1; stalls = 0; stall_run = 0;
        exp_done = (cnt == 0) ? 2 : -1;
        for (c = 1; c < 300; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_valid = (k < nw);
            check("valid", warp_valid, exp_valid);
            check("busy", busy, (exp_done < 0) || (c <= exp_done));
            check("done", done, (c == exp_done));
            if (exp_valid) begin
                check("warp_id", warp_id, k);
                check("warp_base", warp_base, k * WS);
                check("warp_mask", warp_mask, exp_mask(cnt, k));
            end
            if (exp_done >= 0 && c == exp_done + 1) break;
            case (mode)
                0: begin rdy = 1'b1; ret = (outst > 0); end
                2: begin
                    rdy = !(k == 1 && stall_run < 3);
                    if (k == 1 && !rdy) stall_run++;
                    ret = (outst > 0);
                end
                default: begin
                    rdy = ($urandom_range(0, 2) != 0);
                    ret = (outst > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
                    if (exp_done < 0 || c < exp_done) begin
                        if ($urandom_range(0, 3) == 0) begin
                            start = 1'b1;
                            thread_count = TC_W'($urandom_range(0, 20));
                        end
                    end
                end
            endcase
            warp_ready = rdy; warp_retire = ret;
            hs = exp_valid && rdy;
            if (exp_valid && !rdy) stalls++;
            if (hs) begin
                k++;
                if (k == nw) last_hs = c;
            end
            if (hs && !ret) outst++;
            else if (!hs && ret && outst > 0) outst--;
            if (last_hs >= 0 && c > last_hs && z < 0 && outst == 0) begin
                z = c;
                exp_done = c + 2;
            end
        end
        warp_ready = 1'b0; warp_retire = 1'b0; start = 1'b0;
        check("no_timeout", (c < 300), 1);
        check("warps_issued", k, nw);
`ifdef WARP_DISPATCH_PERF_EN
        check("stall_cycles", stall_cycles, stalls);
        check("block_cycles", block_cycles, exp_done);
`else
        check("stall_cycles", stall_cycles, 0);
        check("block_cycles", block_cycles, 0);
`endif
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; thread_count = '0; warp_ready = 1'b0; warp_retire = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", warp_valid, 0);
        check("rst_mask", warp_mask, 0);
        check("rst_block", block_cycles, 0);
        reset = 1'b0;

        run_block(16, 0);
        run_block(6, 0);
        run_block(0, 0);
        run_block(20, 0);
        run_block(16, 2);

        // spurious retires while idle must not leave anything outstanding
        @(negedge clk); warp_retire = 1'b1;
        repeat (2) @(negedge clk);
        warp_retire = 1'b0;
        run_block(9, 0);

        for (int i = 0; i < 8; i++) run_block($urandom_range(0, 20), 1);

        // abort a block with an asynchronous reset
        @(negedge clk); start = 1'b1; thread_count = TC_W'(16); warp_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        check("pre_abort_valid", warp_valid, 1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", warp_valid, 0);
        check("abort_done", done, 0);
        check("abort_id", warp_id, 0);
        check("abort_base", warp_base, 0);
        check("abort_mask", warp_mask, 0);
        check("abort_stall", stall_cycles, 0);
        check("abort_block", block_cycles, 0);
        @(negedge clk); reset = 1'b0;
        run_block(10, 1);
        run_block(13, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
